uart_out_port: RTL

- Memory-mapped output peripheral downstream of the 8-bit CPU data bus.
- When the control unit asserts the port-write strobe, the byte on the data bus is pushed into a small FIFO.
- A transmitter drains the FIFO as 8N1 serial frames on `tx`, LSB first.
- `full` feeds back to the control logic so software/FSM can stall instead of losing bytes.

---
 rtl/uart_out_port.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_out_port.sv
// CPU-bus output port: byte FIFO drained by an 8N1 serial transmitter, LSB first.
// Define UART_OUT_PARITY_EN to insert an even-parity bit between data and stop.
module uart_out_port #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [7:0]               din,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

`ifdef UART_OUT_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;

  logic          empty, full_w, bit_end, push, pop;
  logic [7:0]    head;

  assign empty   = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign head    = mem_q[rd_ptr_q];
  // Full is judged on the registered count, so a same-edge pop never frees a slot.
  assign push    = we && !full_w;
  assign pop     = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      count_q <= count_d;
      if (push)            wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)             rd_ptr_q <= rd_ptr_q + AW'(1);
      if (we && full_w)    ovf_q    <= 1'b1;
      if (state_q != IDLE) timer_q  <= bit_end ? '0 : timer_q + TW'(1);

      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= head;
            par_q   <= ^head;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
`ifdef UART_OUT_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
`ifdef UART_OUT_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            // Next queued byte starts immediately: no idle gap between frames.
            if (pop) begin
              shift_q <= head;
              par_q   <= ^head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign full     = full_w;
  assign count    = count_q;
  assign busy     = (state_q != IDLE) || !empty;
  assign overflow = ovf_q;
  assign tx       = tx_q;

endmodule
